// File: rtl/dffram_pkg.sv
// Shared constants and types for the banked DFFRAM controller.
package dffram_pkg;

  localparam int unsigned LEAF_AW    = 10;
  localparam int unsigned LEAF_WORDS = 1 << LEAF_AW;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WE_W       = 4;
  localparam int unsigned MAX_BANKS  = 16;

  typedef enum logic [0:0] {
    StClear,
    StReady
  } clr_state_e;

  // Request address width: in-bank word bits plus enough bank bits for all leaves.
  function automatic int unsigned bank_addr_w(input int unsigned banks);
    return (banks > 1) ? LEAF_AW + $clog2(banks) : LEAF_AW;
  endfunction

endpackage

// File: rtl/dffram_clear_seq.sv
// Zero-clear sequencer: walks every word address once after reset (optionally) and on
// request, and gates request acceptance while a clear is running or pending.
module dffram_clear_seq
  import dffram_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_req_i,
  output logic               clearing_o,
  output logic [LEAF_AW-1:0] clr_addr_o,
  output logic               init_done_o,
  output logic               req_ready_o
);

  localparam logic [LEAF_AW-1:0] LastWord = LEAF_AW'(LEAF_WORDS - 1);

  clr_state_e         state_q, state_d;
  logic [LEAF_AW-1:0] cnt_q, cnt_d;
  logic               pend_q, pend_d;

  // State, counter and pending flag; reset aborts any clear and restarts from word 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RESET ? StClear : StReady;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: one word per cycle while clearing; a clear request first closes the
  // request port for a cycle so a request accepted alongside it can finish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StClear: begin
        pend_d = 1'b0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastWord) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (pend_q) begin
          state_d = StClear;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (clr_req_i) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = StReady;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    clearing_o  = (state_q == StClear);
    clr_addr_o  = cnt_q;
    init_done_o = (state_q == StReady);
    req_ready_o = (state_q == StReady) && !pend_q;
  end

endmodule

// File: rtl/dffram_leaf.sv
// 1K x 32 word memory leaf with byte write enables and a synchronous read port.
// Data read on an enabled edge is the word content before that edge's write.
module dffram_leaf
  import dffram_pkg::*;
(
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [WE_W-1:0]   we_i,
  input  logic [LEAF_AW-1:0] a_i,
  input  logic [WORD_W-1:0] di_i,
  output logic [WORD_W-1:0] do_o
);

  logic [WORD_W-1:0] mem_q [LEAF_WORDS];

  // Byte-lane write and registered read on every enabled edge.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < WE_W; b++) begin
        if (we_i[b]) begin
          mem_q[a_i][b*8 +: 8] <= di_i[b*8 +: 8];
        end
      end
      do_o <= mem_q[a_i];
    end
  end

endmodule

// File: rtl/dffram_banked_ctrl.sv
// Banked word memory: BANKS leaves of 1K x 32 behind a valid/ready request port with a
// one-cycle response, out-of-range bank errors and a hardware zero-clear sequencer.
module dffram_banked_ctrl
  import dffram_pkg::*;
#(
  parameter int unsigned BANKS          = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW = bank_addr_w(BANKS),
  localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [WE_W-1:0]   REQ_WE,
  input  logic [AW-1:0]     REQ_A,
  input  logic [WORD_W-1:0] Di,
  output logic              RSP_VALID,
  output logic [WORD_W-1:0] Do,
  output logic              RSP_ERR,
  input  logic              CLR_REQ,
  output logic              INIT_DONE
);

  logic               clearing;
  logic [LEAF_AW-1:0] clr_addr;

  logic [BW-1:0] req_bank;
  logic          req_err;
  logic          req_rd;
  logic          accept;

  logic [BANKS-1:0]   leaf_en;
  logic [WE_W-1:0]    leaf_we;
  logic [LEAF_AW-1:0] leaf_a;
  logic [WORD_W-1:0]  leaf_di;
  logic [WORD_W-1:0]  leaf_do [BANKS];

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_rd_q, rsp_rd_d;
  logic [BW-1:0] rsp_bank_q, rsp_bank_d;
  logic [WORD_W-1:0] rd_data;

  dffram_clear_seq #(
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_req_i  (CLR_REQ),
    .clearing_o (clearing),
    .clr_addr_o (clr_addr),
    .init_done_o(INIT_DONE),
    .req_ready_o(REQ_READY)
  );

  // Bank decode; only a non-power-of-two bank count can address a missing leaf.
  if (BANKS > 1) begin : g_multi
    assign req_bank = REQ_A[AW-1:LEAF_AW];
    if ((1 << BW) == BANKS) begin : g_pow2
      assign req_err = 1'b0;
    end else begin : g_npow2
      assign req_err = (req_bank > BW'(BANKS - 1));
    end
  end else begin : g_single
    assign req_bank = '0;
    assign req_err  = 1'b0;
  end

  assign accept = REQ_VALID & REQ_READY;
  assign req_rd = (REQ_WE == '0);

  // Leaf port mux: the clear path drives every leaf, the request path only the addressed one.
  always_comb begin
    leaf_we = clearing ? '1 : REQ_WE;
    leaf_a  = clearing ? clr_addr : REQ_A[LEAF_AW-1:0];
    leaf_di = clearing ? '0 : Di;
    for (int i = 0; i < BANKS; i++) begin
      leaf_en[i] = clearing | (accept & ~req_err & (req_bank == BW'(i)));
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_leaf
    dffram_leaf u_leaf (
      .clk_i(CLK),
      .en_i (leaf_en[g]),
      .we_i (leaf_we),
      .a_i  (leaf_a),
      .di_i (leaf_di),
      .do_o (leaf_do[g])
    );
  end

  // Response pipeline next-state: bank and error are captured with the request so the
  // output mux never looks at the live address.
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept & req_err;
    rsp_rd_d    = accept & req_rd & ~req_err;
    rsp_bank_d  = accept ? req_bank : rsp_bank_q;
  end

  // Response pipeline register, aligned with the leaf's synchronous read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_bank_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  // Read data mux; zero unless this cycle carries a successful read response.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (rsp_bank_q == BW'(i)) begin
        rd_data = leaf_do[i];
      end
    end
    Do        = (rsp_valid_q & rsp_rd_q) ? rd_data : '0;
    RSP_VALID = rsp_valid_q;
    RSP_ERR   = rsp_err_q;
  end

endmodule

// File: tb/tb_dffram_banked_ctrl.sv
// Directed bench for dffram_banked_ctrl: an 8-bank and a 6-bank instance share stimulus;
// expected responses come from a word-memory model and are queued per request.
module tb_dffram_banked_ctrl;

  localparam int unsigned AW = 13;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic [3:0]    REQ_WE = '0;
  logic [AW-1:0] REQ_A = '0;
  logic [31:0]   Di = '0;
  logic          CLR_REQ = 1'b0;

  logic        rdy8, rv8, err8, init8;
  logic [31:0] do8;
  logic        rdy6, rv6, err6, init6;
  logic [31:0] do6;

  always #5 CLK = ~CLK;

  dffram_banked_ctrl #(.BANKS(8), .CLEAR_ON_RESET(1'b1)) dut8 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy8), .REQ_WE(REQ_WE),
    .REQ_A(REQ_A), .Di(Di), .RSP_VALID(rv8), .Do(do8), .RSP_ERR(err8),
    .CLR_REQ(CLR_REQ), .INIT_DONE(init8)
  );

  dffram_banked_ctrl #(.BANKS(6), .CLEAR_ON_RESET(1'b1)) dut6 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy6), .REQ_WE(REQ_WE),
    .REQ_A(REQ_A), .Di(Di), .RSP_VALID(rv6), .Do(do6), .RSP_ERR(err6),
    .CLR_REQ(CLR_REQ), .INIT_DONE(init6)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q8[$];
  exp_t        q6[$];
  logic [31:0] mem8[int];
  logic [31:0] mem6[int];
  int          checks = 0;
  int          failures = 0;

  // Leaf enables outside bank 1 while the bank-1 sequence runs.
  logic       mon_en = 1'b0;
  logic [7:0] foreign_en = '0;
  always @(posedge CLK) if (mon_en) foreign_en <= foreign_en | (dut8.leaf_en & 8'hFD);

  // Responses seen while requests are held against a clear in progress.
  logic win = 1'b0;
  int   rsp_seen = 0;
  always @(negedge CLK) if (win) rsp_seen <= rsp_seen + int'(rv8 | rv6);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Model one accepted request on both instances and queue the expected responses.
  task automatic model(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] old;
    int          bank;
    bank = int'(a >> 10);
    old = mem8.exists(int'(a)) ? mem8[int'(a)] : 32'h0;
    e.err  = (bank >= 8);
    e.data = (!e.err && we == 4'h0) ? old : 32'h0;
    q8.push_back(e);
    if (!e.err && we != 4'h0) mem8[int'(a)] = merge(old, d, we);
    old = mem6.exists(int'(a)) ? mem6[int'(a)] : 32'h0;
    e.err  = (bank >= 6);
    e.data = (!e.err && we == 4'h0) ? old : 32'h0;
    q6.push_back(e);
    if (!e.err && we != 4'h0) mem6[int'(a)] = merge(old, d, we);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e8, e6;
    e8 = q8.pop_front();
    e6 = q6.pop_front();
    chk({tag, "_valid8"}, 32'(rv8), 32'd1);
    chk({tag, "_err8"}, 32'(err8), 32'(e8.err));
    chk({tag, "_do8"}, do8, e8.data);
    chk({tag, "_valid6"}, 32'(rv6), 32'd1);
    chk({tag, "_err6"}, 32'(err6), 32'(e6.err));
    chk({tag, "_do6"}, do6, e6.data);
  endtask

  // Drive one request, wait (bounded) for ready, then check the response after the edge.
  // Leaves REQ_VALID low, so back-to-back calls keep the port busy every cycle.
  task automatic do_req(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic clr, input string tag);
    int w;
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_A     = a;
    Di        = d;
    CLR_REQ   = clr;
    w = 0;
    while (!(rdy8 && rdy6) && w < 64) begin
      @(posedge CLK);
      #1;
      w++;
    end
    chk({tag, "_ready"}, 32'(rdy8 && rdy6), 32'd1);
    model(we, a, d);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    CLR_REQ   = 1'b0;
    check_rsp(tag);
  endtask

  // Called at the negedge where RST falls; that cycle counts as cycle 1.
  task automatic wait_init(input string tag);
    int n;
    n = 1;
    while (!(init8 && init6) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(n), 32'd1025);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1: reset values, clear after reset, reads of the extreme addresses.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(rdy8), 32'd0);
    chk("rst_rsp_valid", 32'(rv8), 32'd0);
    chk("rst_rsp_err", 32'(err8), 32'd0);
    chk("rst_do", do8, 32'h0);
    chk("rst_init_done", 32'(init8 | init6), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    wait_init("t1_init_cycles");
    do_req(4'h0, 13'h0000, 32'h0, 1'b0, "t1_rd_0000");
    do_req(4'h0, 13'h1FFF, 32'h0, 1'b0, "t1_rd_1FFF");

    // 2: byte-lane merge in bank 1; no other leaf enabled meanwhile.
    mon_en = 1'b1;
    do_req(4'hF, 13'h0400, 32'hDEADBEEF, 1'b0, "t2_wr_full");
    do_req(4'b0010, 13'h0400, 32'h0000AA00, 1'b0, "t2_wr_lane1");
    do_req(4'h0, 13'h0400, 32'h0, 1'b0, "t2_rd");
    chk("t2_rd_value", do8, 32'hDEADAAEF);
    @(negedge CLK);
    mon_en = 1'b0;
    chk("t2_foreign_en", 32'(foreign_en), 32'h0);

    // 3: back-to-back reads across banks.
    do_req(4'hF, 13'h0005, 32'h11, 1'b0, "t3_wr0");
    do_req(4'hF, 13'h1C05, 32'h77, 1'b0, "t3_wr7");
    do_req(4'hF, 13'h0805, 32'h22, 1'b0, "t3_wr2");
    @(negedge CLK);
    do_req(4'h0, 13'h0005, 32'h0, 1'b0, "t3_rd0");
    do_req(4'h0, 13'h1C05, 32'h0, 1'b0, "t3_rd7");
    chk("t3_rd7_value", do8, 32'h77);
    do_req(4'h0, 13'h0805, 32'h0, 1'b0, "t3_rd2");

    // 4: missing banks on the 6-bank instance, present on the 8-bank one.
    do_req(4'hF, 13'h1400, 32'h55AA1234, 1'b0, "t4_wr_1400");
    do_req(4'hF, 13'h1800, 32'hCAFEF00D, 1'b0, "t4_wr_1800");
    do_req(4'hF, 13'h1FFF, 32'h12345678, 1'b0, "t4_wr_1FFF");
    do_req(4'h0, 13'h1800, 32'h0, 1'b0, "t4_rd_1800");
    chk("t4_rd_1800_err6", 32'(err6), 32'd1);
    do_req(4'h0, 13'h1FFF, 32'h0, 1'b0, "t4_rd_1FFF");
    do_req(4'h0, 13'h1400, 32'h0, 1'b0, "t4_rd_1400");
    chk("t4_rd_1400_do6", do6, 32'h55AA1234);

    // 5: clear request alongside a write; a second request mid-clear is ignored.
    @(negedge CLK);
    do_req(4'hF, 13'h0400, 32'h01020304, 1'b1, "t5_wr_clr");
    chk("t5_ready_drop", 32'(rdy8), 32'd0);
    n = 0;
    while (!rdy8 && n < 3000) begin
      @(posedge CLK);
      #1;
      n++;
      CLR_REQ = (n == 100);
    end
    CLR_REQ = 1'b0;
    chk("t5_busy_len_ok", 32'(n >= 1024 && n <= 1040), 32'd1);
    mem8.delete();
    mem6.delete();
    do_req(4'h0, 13'h0400, 32'h0, 1'b0, "t5_rd_0400");
    do_req(4'h0, 13'h0005, 32'h0, 1'b0, "t5_rd_0005");
    do_req(4'h0, 13'h1C05, 32'h0, 1'b0, "t5_rd_1C05");
    do_req(4'h0, 13'h0805, 32'h0, 1'b0, "t5_rd_0805");
    do_req(4'h0, 13'h1400, 32'h0, 1'b0, "t5_rd_1400");
    chk("t5_rd_1400_do8", do8, 32'h0);

    // 6: reset in the middle of a clear, with a request held valid throughout.
    CLR_REQ = 1'b1;
    @(posedge CLK);
    #1;
    CLR_REQ = 1'b0;
    repeat (501) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("t6_rst_init_done", 32'(init8), 32'd0);
    chk("t6_rst_ready", 32'(rdy8), 32'd0);
    REQ_VALID = 1'b1;
    REQ_WE    = 4'h0;
    REQ_A     = 13'h0005;
    win       = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    wait_init("t6_init_cycles");
    REQ_VALID = 1'b0;
    win       = 1'b0;
    chk("t6_no_early_rsp", 32'(rsp_seen), 32'd0);
    do_req(4'h0, 13'h0005, 32'h0, 1'b0, "t6_rd_0005");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
